// File: rtl/cc3000_pkg.sv
// rtl/cc3000_pkg.sv - shared types and constants for the CC3000 SPI link
package cc3000_pkg;

  localparam int LEN_W               = 11;
  localparam int TO_W                = 20;
  localparam int CLK_DIV_DEFAULT     = 2;
  localparam int IRQ_TIMEOUT_DEFAULT = 65535;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IRQ,
    SHIFT,
    FINISH
  } state_t;

endpackage

// File: rtl/cc3000_spi_link_if.sv
// rtl/cc3000_spi_link_if.sv - host-side transaction handshake bundle
interface cc3000_spi_link_if;
  import cc3000_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic [7:0]       tx_data;
  logic             tx_ack;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             done;
  logic             err;

  modport master (
    output start, len, tx_data,
    input  busy, tx_ack, rx_data, rx_valid, done, err
  );

  modport slave (
    input  start, len, tx_data,
    output busy, tx_ack, rx_data, rx_valid, done, err
  );

endinterface

// File: rtl/cc3000_spi_shift.sv
// rtl/cc3000_spi_shift.sv - mode-1 SPI byte shifter with SCLK generation
module cc3000_spi_shift
  import cc3000_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_end,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic [3:0] half_cnt;
  logic [7:0] tx_sr;
  logic [6:0] rx_sr;
  logic       tick;

  // One SCLK half-period elapses; the 16th half-period closes the byte on a falling edge.
  assign tick     = en && (div_cnt == DIV_LAST);
  assign byte_end = tick && (half_cnt == 4'd15);

  // Half-period timing, MOSI on rising edges, MISO capture on falling edges; load wins last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!en) begin
        div_cnt  <= '0;
        half_cnt <= '0;
        sclk     <= 1'b0;
        mosi     <= 1'b0;
      end else if (tick) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 4'd1;
        sclk     <= ~sclk;
        if (!sclk) begin
          mosi <= tx_sr[7];
        end else begin
          tx_sr <= {tx_sr[6:0], 1'b0};
          rx_sr <= {rx_sr[5:0], miso};
          if (half_cnt == 4'd15) begin
            rx_data  <= {rx_sr, miso};
            rx_valid <= 1'b1;
            mosi     <= 1'b0;
          end
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      // The MSB must be on the wire from the load cycle, ahead of the first rising edge.
      if (load) begin
        tx_sr    <= load_data;
        mosi     <= load_data[7];
        div_cnt  <= '0;
        half_cnt <= '0;
        sclk     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cc3000_spi_link.sv
// rtl/cc3000_spi_link.sv - CC3000 SPI transaction controller
module cc3000_spi_link
  import cc3000_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEFAULT,
  parameter int IRQ_TIMEOUT = IRQ_TIMEOUT_DEFAULT
) (
  input  logic               SYSCLK,
  input  logic               NSYSRESET,
  cc3000_spi_link_if.slave   host,
  output logic               SPI_SCLK,
  output logic               SPI_CS_N,
  output logic               SPI_MOSI,
  input  logic               SPI_MISO,
  input  logic               CC_IRQ_N
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IRQ_TIMEOUT - 1);

  state_t           state;
  logic             irq_meta;
  logic             irq_sync;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] byte_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             byte_end;
  logic             load;

  // Bring the asynchronous IRQ line into the SYSCLK domain; idles high.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      irq_meta <= 1'b1;
      irq_sync <= 1'b1;
    end else begin
      irq_meta <= CC_IRQ_N;
      irq_sync <= irq_meta;
    end
  end

  // A byte enters the shifter when IRQ arrives, or back-to-back while bytes remain.
  assign load = ((state == WAIT_IRQ) && !irq_sync) ||
                ((state == SHIFT) && byte_end && (byte_cnt != len_q));

  // Transaction sequencing; byte_cnt counts bytes loaded so it never exceeds len.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state       <= IDLE;
      host.busy   <= 1'b0;
      host.tx_ack <= 1'b0;
      host.done   <= 1'b0;
      host.err    <= 1'b0;
      SPI_CS_N    <= 1'b1;
      len_q       <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      host.tx_ack <= load;
      host.done   <= 1'b0;
      host.err    <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            if (host.len == '0) begin
              host.done <= 1'b1;
            end else begin
              len_q     <= host.len;
              byte_cnt  <= '0;
              to_cnt    <= '0;
              host.busy <= 1'b1;
              SPI_CS_N  <= 1'b0;
              state     <= WAIT_IRQ;
            end
          end
        end
        WAIT_IRQ: begin
          if (!irq_sync) begin
            byte_cnt <= LEN_W'(1);
            state    <= SHIFT;
          end else if (to_cnt == TO_LAST) begin
            SPI_CS_N  <= 1'b1;
            host.done <= 1'b1;
            host.err  <= 1'b1;
            state     <= FINISH;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        SHIFT: begin
          if (byte_end) begin
            if (byte_cnt != len_q) begin
              byte_cnt <= byte_cnt + LEN_W'(1);
            end else begin
              SPI_CS_N  <= 1'b1;
              host.done <= 1'b1;
              state     <= FINISH;
            end
          end
        end
        FINISH: begin
          host.busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cc3000_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk       (SYSCLK),
    .rst_n     (NSYSRESET),
    .en        (state == SHIFT),
    .load      (load),
    .load_data (host.tx_data),
    .miso      (SPI_MISO),
    .sclk      (SPI_SCLK),
    .mosi      (SPI_MOSI),
    .byte_end  (byte_end),
    .rx_data   (host.rx_data),
    .rx_valid  (host.rx_valid)
  );

endmodule

// File: tb/tb_cc3000_spi_link.sv
// tb/tb_cc3000_spi_link.sv - self-checking bench for cc3000_spi_link
module tb_cc3000_spi_link;
  import cc3000_pkg::*;

  localparam int CD = 2;

  typedef struct {
    int          len;
    logic [63:0] data;
    bit          fixed;
    bit          lp;
    int          irq_dly;
    int          inj;
    int          exp_edges;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic irq_n = 1'b1;
  logic miso_drv = 1'b0;
  logic loop_en = 1'b0;
  logic sclk, cs_n, mosi, miso;
  logic sclk2, cs_n2, mosi2;

  always #5 clk = ~clk;
  assign miso = loop_en ? mosi : miso_drv;

  cc3000_spi_link_if hif ();
  cc3000_spi_link_if hif2 ();

  cc3000_spi_link dut (
    .SYSCLK(clk), .NSYSRESET(rst_n), .host(hif),
    .SPI_SCLK(sclk), .SPI_CS_N(cs_n), .SPI_MOSI(mosi),
    .SPI_MISO(miso), .CC_IRQ_N(irq_n)
  );

  cc3000_spi_link #(.CLK_DIV(CD), .IRQ_TIMEOUT(100)) dut_to (
    .SYSCLK(clk), .NSYSRESET(rst_n), .host(hif2),
    .SPI_SCLK(sclk2), .SPI_CS_N(cs_n2), .SPI_MOSI(mosi2),
    .SPI_MISO(1'b0), .CC_IRQ_N(1'b1)
  );

  int checks = 0, failures = 0;
  int rises = 0, acks = 0, dones = 0, rises2 = 0, dones2 = 0, cs2_low = 0, cs_low = 0;
  int idle_viol = 0, rst_viol = 0, ack_base = 0;
  logic last_err = 1'b0, last_err2 = 1'b0;
  logic prev_sclk = 1'b0, prev_sclk2 = 1'b0;
  bit mosi_q[$];
  bit miso_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_arr[0:2047];
  vec_t vecs[6];

  // Slave-side model: observes both links, feeds random MISO bits and serves tx bytes.
  always @(negedge clk) begin : mon
    int idx;
    if (sclk && !prev_sclk) begin
      rises++;
      mosi_q.push_back(mosi);
      if (!loop_en) begin
        miso_drv = 1'($urandom_range(1));
        miso_q.push_back(miso_drv);
      end
    end
    prev_sclk = sclk;
    if (sclk2 && !prev_sclk2) rises2++;
    prev_sclk2 = sclk2;
    if (hif.rx_valid) rx_q.push_back(hif.rx_data);
    if (hif.tx_ack) acks++;
    if (hif.done) begin dones++; last_err = hif.err; end
    if (hif2.done) begin dones2++; last_err2 = hif2.err; end
    if (!cs_n2) cs2_low++;
    if (!cs_n) cs_low++;
    if (cs_n && (sclk || mosi)) idle_viol++;
    if (!rst_n && (!cs_n || sclk || hif.busy)) rst_viol++;
    idx = acks - ack_base;
    if (idx < 0 || idx > 2047) idx = 0;
    hif.tx_data = tx_arr[idx];
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input int n, input bit lp, input int irq_dly,
                         input int inj, input int exp_edges);
    int m0, q0, x0, r0, a0, d0, cyc, limit, bad;
    logic [7:0] exp_b, got_b;
    loop_en = lp;
    tick();
    ack_base = acks;
    m0 = mosi_q.size(); q0 = miso_q.size(); x0 = rx_q.size();
    r0 = rises; a0 = acks; d0 = dones;
    tick();
    if (irq_dly == 0) irq_n = 1'b0;
    hif.start = 1'b1;
    hif.len = 11'(n);
    tick();
    hif.start = 1'b0;
    cyc = 1;
    limit = irq_dly + n * 16 * CD + 300;
    while (dones == d0 && cyc < limit) begin
      if (cyc == irq_dly) irq_n = 1'b0;
      if (cyc == inj) begin hif.start = 1'b1; hif.len = 11'd5; end
      else hif.start = 1'b0;
      tick();
      cyc++;
    end
    hif.start = 1'b0;
    irq_n = 1'b1;
    check({tag, " done seen"}, longint'(dones != d0), 1);
    check({tag, " err"}, last_err, 0);
    check({tag, " tx_ack count"}, acks - a0, n);
    check({tag, " rising edges"}, rises - r0, exp_edges);
    bad = 0;
    for (int b = 0; b < n; b++) begin
      if (mosi_q.size() < m0 + 8 * n) begin bad++; continue; end
      for (int k = 0; k < 8; k++) got_b[7-k] = mosi_q[m0 + 8*b + k];
      if (got_b !== tx_arr[b]) bad++;
    end
    check({tag, " mosi bytes wrong"}, bad, 0);
    check({tag, " rx_valid count"}, rx_q.size() - x0, n);
    bad = 0;
    for (int b = 0; b < n; b++) begin
      if (rx_q.size() < x0 + n || (!lp && miso_q.size() < q0 + 8 * n)) begin bad++; continue; end
      if (lp) exp_b = tx_arr[b];
      else for (int k = 0; k < 8; k++) exp_b[7-k] = miso_q[q0 + 8*b + k];
      if (rx_q[x0 + b] !== exp_b) bad++;
    end
    check({tag, " rx bytes wrong"}, bad, 0);
    tick();
    check({tag, " busy after done"}, hif.busy, 0);
    check({tag, " cs_n after done"}, cs_n, 1);
    check({tag, " single done"}, dones - d0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, r0, c0, cyc, n, x0;
    hif.start = 1'b0; hif.len = '0;
    hif2.start = 1'b0; hif2.len = '0; hif2.tx_data = '0;
    for (int i = 0; i < 2048; i++) tx_arr[i] = '0;

    vecs[0] = '{5, 64'h0100050000000000, 1'b1, 1'b0, 200, -1, 40};
    vecs[1] = '{3, 64'hA55AFF0000000000, 1'b1, 1'b1, 10, -1, 24};
    vecs[2] = '{1, 64'h0, 1'b0, 1'b0, 3, -1, 8};
    vecs[3] = '{7, 64'h0, 1'b0, 1'b0, 0, -1, 56};
    vecs[4] = '{4, 64'h0, 1'b0, 1'b1, 25, -1, 32};
    vecs[5] = '{2, 64'h0, 1'b0, 1'b0, 5, 60, 16};

    // Reset held for 1000 ns.
    #1 rst_n = 1'b0;
    #1000;
    check("reset cs_n", cs_n, 1);
    check("reset sclk", sclk, 0);
    check("reset busy", hif.busy, 0);
    check("reset rx_data", hif.rx_data, 0);
    check("reset done/tx_ack/rx_valid", {hif.done, hif.tx_ack, hif.rx_valid}, 0);
    check("reset violations", rst_viol, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].len; b++)
        tx_arr[b] = vecs[v].fixed ? vecs[v].data[63 - 8*b -: 8] : 8'($urandom);
      run_txn($sformatf("vec%0d", v), vecs[v].len, vecs[v].lp, vecs[v].irq_dly,
              vecs[v].inj, vecs[v].exp_edges);
    end

    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 9);
      for (int b = 0; b < n; b++) tx_arr[b] = 8'($urandom);
      run_txn($sformatf("rand%0d", i), n, 1'($urandom_range(1)),
              $urandom_range(0, 40), -1, 8 * n);
    end

    // len = 0: done next cycle, chip select untouched.
    d0 = dones; r0 = rises; c0 = cs_low;
    hif.start = 1'b1; hif.len = '0;
    tick();
    hif.start = 1'b0;
    check("len0 done next cycle", hif.done, 1);
    check("len0 err", hif.err, 0);
    tick();
    check("len0 done pulse width", hif.done, 0);
    check("len0 done count", dones - d0, 1);
    check("len0 cs never low", cs_low - c0, 0);
    check("len0 no sclk", rises - r0, 0);
    check("len0 busy", hif.busy, 0);

    // IRQ timeout on the second instance.
    d0 = dones2; r0 = rises2; c0 = cs2_low;
    hif2.start = 1'b1; hif2.len = 11'd3;
    tick();
    hif2.start = 1'b0;
    cyc = 1;
    while (dones2 == d0 && cyc < 400) begin tick(); cyc++; end
    check("timeout done seen", longint'(dones2 != d0), 1);
    check("timeout err", last_err2, 1);
    check("timeout latency in 98..104", longint'(cyc >= 98 && cyc <= 104), 1);
    check("timeout no sclk", rises2 - r0, 0);
    check("timeout cs went low", longint'(cs2_low - c0 > 0), 1);
    tick();
    check("timeout busy released", hif2.busy, 0);
    check("timeout cs_n released", cs_n2, 1);

    // Reset after two of four bytes.
    for (int b = 0; b < 4; b++) tx_arr[b] = 8'($urandom);
    loop_en = 1'b0;
    tick();
    ack_base = acks;
    x0 = rx_q.size();
    tick();
    irq_n = 1'b0;
    hif.start = 1'b1; hif.len = 11'd4;
    tick();
    hif.start = 1'b0;
    cyc = 0;
    while (rx_q.size() - x0 < 2 && cyc < 400) begin tick(); cyc++; end
    check("abort two bytes received", rx_q.size() - x0, 2);
    check("abort cs low before reset", cs_n, 0);
    d0 = dones;
    #2 rst_n = 1'b0;
    #1;
    check("abort cs_n immediate", cs_n, 1);
    check("abort busy immediate", hif.busy, 0);
    check("abort sclk immediate", sclk, 0);
    irq_n = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort no done", dones - d0, 0);
    tx_arr[0] = 8'($urandom);
    run_txn("after abort", 1, 1'b0, 4, -1, 8);

    check("mosi/sclk quiet while cs_n high", idle_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
